// File: rtl/countdown_pkg.sv
// Shared encodings and sizing helpers for the countdown-timer controller.
package countdown_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned DISP_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_STOPPED = 2'd1,
      ST_RUN     = 2'd2,
      ST_ALARM   = 2'd3
   } state_t;

   localparam logic [DISP_W-1:0] DISP_ON  = 2'b11;
   localparam logic [DISP_W-1:0] DISP_OFF = 2'b00;

   // Clock cycles per buzzer half-period.
   function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                               input int unsigned blink_hz);
      return clk_hz / (2 * blink_hz);
   endfunction

endpackage

// File: rtl/blink_tick.sv
// Alarm blink prescaler with toggle counter; held cleared while restart is high.
// phase is the buzzer level that applies after the current edge and expired
// flags the edge that completes the final toggle.
module blink_tick #(
   parameter int unsigned HALF    = 4,
   parameter int unsigned TOGGLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic phase,
   output logic expired
);

   localparam int unsigned PRE_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned CNT_W = $clog2(TOGGLES + 1);

   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap    = !restart && (pre == PRE_W'(HALF - 1));
   // Buzzer is high while an even number of toggles has completed.
   assign phase   = ~(cnt[0] ^ wrap);
   assign expired = wrap && (cnt == CNT_W'(TOGGLES - 1));

   // Prescaler and toggle counter; both restart from zero on ALARM entry.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         pre <= '0;
         cnt <= '0;
      end else if (wrap) begin
         pre <= '0;
         cnt <= cnt + CNT_W'(1);
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

endmodule

// File: rtl/countdown_controller.sv
// Mode sequencer for the countdown timer: turns button pulses into one-cycle
// counter commands and tracks IDLE/STOPPED/RUN/ALARM with a timed alarm.
module countdown_controller
   import countdown_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned BLINK_HZ  = 2,
   parameter int unsigned BUZZ_SECS = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_pulse,
   input  logic                 plus_pulse,
   input  logic                 clear_pulse,
   input  logic                 time_zero,
   output logic                 cnt_enable,
   output logic                 cnt_plus,
   output logic                 cnt_clear,
   output logic                 buzzer,
   output logic [DISP_W-1:0]    disp_enable,
   output logic [STATE_W-1:0]   state_o
);

   localparam int unsigned HALF    = half_cycles(CLK_HZ, BLINK_HZ);
   localparam int unsigned TOGGLES = BUZZ_SECS * 2 * BLINK_HZ;

   state_t state;
   logic   phase;
   logic   expired;
   logic   any_pulse;

   assign any_pulse = start_pulse | plus_pulse | clear_pulse;
   assign state_o   = state;

   blink_tick #(
      .HALF    (HALF),
      .TOGGLES (TOGGLES)
   ) u_blink (
      .clk     (clk),
      .reset   (reset),
      .restart (state != ST_ALARM),
      .phase   (phase),
      .expired (expired)
   );

   // State transitions with registered command, enable and alarm outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt_enable  <= 1'b0;
         cnt_plus    <= 1'b0;
         cnt_clear   <= 1'b0;
         buzzer      <= 1'b0;
         disp_enable <= DISP_ON;
      end else begin
         cnt_plus  <= 1'b0;
         cnt_clear <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (plus_pulse) begin
                  cnt_plus <= 1'b1;
                  state    <= ST_STOPPED;
               end
            end
            ST_STOPPED: begin
               if (clear_pulse) begin
                  cnt_clear <= 1'b1;
                  state     <= ST_IDLE;
               end else if (start_pulse) begin
                  // Starting with nothing on the clock falls back to IDLE.
                  if (time_zero) begin
                     state <= ST_IDLE;
                  end else begin
                     state      <= ST_RUN;
                     cnt_enable <= 1'b1;
                  end
               end else if (plus_pulse) begin
                  cnt_plus <= 1'b1;
               end
            end
            ST_RUN: begin
               if (clear_pulse) begin
                  cnt_clear  <= 1'b1;
                  cnt_enable <= 1'b0;
                  state      <= ST_IDLE;
               end else if (time_zero) begin
                  cnt_enable  <= 1'b0;
                  buzzer      <= 1'b1;
                  disp_enable <= DISP_ON;
                  state       <= ST_ALARM;
               end else if (start_pulse) begin
                  cnt_enable <= 1'b0;
                  state      <= ST_STOPPED;
               end
            end
            ST_ALARM: begin
               if (any_pulse || expired) begin
                  buzzer      <= 1'b0;
                  disp_enable <= DISP_ON;
                  state       <= ST_IDLE;
               end else begin
                  buzzer      <= phase;
                  disp_enable <= phase ? DISP_ON : DISP_OFF;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_controller.sv
// Directed bench for countdown_controller with a cycle-level reference model.
module tb_countdown_controller;

   localparam int unsigned CLK_HZ    = 8;
   localparam int unsigned BLINK_HZ  = 1;
   localparam int unsigned BUZZ_SECS = 2;
   localparam int HALF_C   = CLK_HZ / (2 * BLINK_HZ);
   localparam int ALARM_LEN = HALF_C * BUZZ_SECS * 2 * BLINK_HZ;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_pulse = 1'b0;
   logic       plus_pulse = 1'b0;
   logic       clear_pulse = 1'b0;
   logic       time_zero = 1'b0;
   logic       cnt_enable, cnt_plus, cnt_clear, buzzer;
   logic [1:0] disp_enable, state_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model: state number and cycles spent in the alarm
   int m_st  = 0;
   int m_age = 0;
   int m_plus = 0;
   int m_clr  = 0;

   countdown_controller #(
      .CLK_HZ    (CLK_HZ),
      .BLINK_HZ  (BLINK_HZ),
      .BUZZ_SECS (BUZZ_SECS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_pulse (start_pulse),
      .plus_pulse  (plus_pulse),
      .clear_pulse (clear_pulse),
      .time_zero   (time_zero),
      .cnt_enable  (cnt_enable),
      .cnt_plus    (cnt_plus),
      .cnt_clear   (cnt_clear),
      .buzzer      (buzzer),
      .disp_enable (disp_enable),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each rising edge from the mode rules.
   always @(posedge clk) begin
      int st, age, p, c;
      st = m_st; age = m_age; p = 0; c = 0;
      if (reset) begin
         st = 0; age = 0;
      end else begin
         case (st)
            0: if (plus_pulse) begin p = 1; st = 1; end
            1: begin
               if (clear_pulse) begin c = 1; st = 0; end
               else if (start_pulse) st = time_zero ? 0 : 2;
               else if (plus_pulse) p = 1;
            end
            2: begin
               if (clear_pulse) begin c = 1; st = 0; end
               else if (time_zero) begin st = 3; age = 0; end
               else if (start_pulse) st = 1;
            end
            default: begin
               if (start_pulse || plus_pulse || clear_pulse || age == ALARM_LEN - 1) st = 0;
               else age = age + 1;
            end
         endcase
      end
      m_st <= st; m_age <= age; m_plus <= p; m_clr <= c;
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         int e_buz, e_disp;
         e_buz  = (m_st == 3 && ((m_age / HALF_C) % 2) == 0) ? 1 : 0;
         e_disp = (m_st == 3) ? (e_buz ? 3 : 0) : 3;
         chk("model_state", int'(state_o), m_st);
         chk("model_cnt_enable", int'(cnt_enable), (m_st == 2) ? 1 : 0);
         chk("model_cnt_plus", int'(cnt_plus), m_plus);
         chk("model_cnt_clear", int'(cnt_clear), m_clr);
         chk("model_buzzer", int'(buzzer), e_buz);
         chk("model_disp", int'(disp_enable), e_disp);
      end
   end

   task automatic step(input logic s, input logic p, input logic c);
      start_pulse = s; plus_pulse = p; clear_pulse = c;
      @(negedge clk);
      start_pulse = 1'b0; plus_pulse = 1'b0; clear_pulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // From IDLE, load a value, start and let time_zero fire the alarm.
   task automatic enter_alarm();
      time_zero = 1'b0;
      step(0, 1, 0);
      step(1, 0, 0);
      idle(1);
      time_zero = 1'b1;
      idle(1);
      time_zero = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // 1. reset and first plus
      idle(2);
      chk("rst_state", int'(state_o), 0);
      chk("rst_disp", int'(disp_enable), 3);
      chk("rst_buzzer", int'(buzzer), 0);
      chk("rst_enable", int'(cnt_enable), 0);
      reset = 1'b0;
      chk_en = 1'b1;
      step(0, 0, 1);
      chk("idle_clear_ignored", int'(cnt_clear), 0);
      step(0, 1, 0);
      chk("idle_plus_cmd", int'(cnt_plus), 1);
      chk("idle_plus_state", int'(state_o), 1);
      idle(1);
      chk("plus_one_cycle", int'(cnt_plus), 0);
      step(0, 1, 0);
      chk("stopped_plus", int'(cnt_plus), 1);

      // 2. start/stop
      step(1, 0, 0);
      chk("run_state", int'(state_o), 2);
      chk("run_enable", int'(cnt_enable), 1);
      step(0, 1, 0);
      chk("run_plus_ignored", int'(cnt_plus), 0);
      idle(2);
      step(1, 0, 0);
      chk("stop_state", int'(state_o), 1);
      chk("stop_enable", int'(cnt_enable), 0);

      // 3. alarm runs to auto-silence
      step(1, 0, 0);
      time_zero = 1'b1;
      idle(1);
      time_zero = 1'b0;
      chk("alarm_state", int'(state_o), 3);
      chk("alarm_buzzer", int'(buzzer), 1);
      n = 1;
      while (state_o == 2'd3 && n < 40) begin
         @(negedge clk);
         if (state_o == 2'd3) begin
            n++;
            if (n == 5) chk("alarm_first_toggle", int'(buzzer), 0);
            if (n == 9) chk("alarm_second_toggle", int'(buzzer), 1);
         end
      end
      chk("alarm_length", n, 16);
      chk("alarm_exit_buzzer", int'(buzzer), 0);
      chk("alarm_exit_disp", int'(disp_enable), 3);

      // 4. plus silences the alarm without a command
      enter_alarm();
      idle(2);
      step(0, 1, 0);
      chk("silence_state", int'(state_o), 0);
      chk("silence_buzzer", int'(buzzer), 0);
      chk("silence_no_plus", int'(cnt_plus), 0);

      // 5. clear beats start in RUN
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      chk("clear_cmd", int'(cnt_clear), 1);
      chk("clear_state", int'(state_o), 0);
      idle(1);
      chk("clear_one_cycle", int'(cnt_clear), 0);

      // 6. reset mid-alarm, then start with nothing loaded
      enter_alarm();
      idle(7);
      chk("pre_reset_buzzer", int'(buzzer), 0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk("reset_alarm_buzzer", int'(buzzer), 0);
      chk("reset_alarm_state", int'(state_o), 0);
      step(0, 1, 0);
      time_zero = 1'b1;
      step(1, 0, 0);
      time_zero = 1'b0;
      chk("start_zero_state", int'(state_o), 0);
      chk("start_zero_enable", int'(cnt_enable), 0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
